prv32_alu_issue: RTL

// - Decode/issue stage that feeds the RV32 ALU: produces the ALU control word, shift amount and operand selects.
// - Takes a 32-bit instruction over a valid/ready handshake and decodes opcode, funct3 and funct7[5].
// - Returns the result through a registered pipeline stage with a skid buffer.
// - Sits between fetch/regfile read and the combinational ALU; downstream drives ALU inputs a/b/shamt/alufn.

---
 rtl/prv32_alu_issue.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/prv32_alu_issue.sv
// ============================================================================
// Module      : prv32_alu_issue
// Description : RV32I decode/issue stage producing ALU control, operand selects
//               and immediates behind a registered valid/ready output stage.
//               Optional 2-entry skid buffer via PRV32_ALU_ISSUE_SKID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prv32_alu_issue #(
    parameter logic [3:0] RST_ALUFN = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_alufn,
    output logic [4:0]  out_shamt,
    output logic        out_shamt_sel,
    output logic        out_b_imm,
    output logic        out_a_pc,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] c_ALU_ADD   = 4'b0000;
    localparam logic [3:0] c_ALU_SUB   = 4'b0001;
    localparam logic [3:0] c_ALU_PASSB = 4'b0011;
    localparam logic [3:0] c_ALU_OR    = 4'b0100;
    localparam logic [3:0] c_ALU_AND   = 4'b0101;
    localparam logic [3:0] c_ALU_XOR   = 4'b0111;
    localparam logic [3:0] c_ALU_SRL   = 4'b1000;
    localparam logic [3:0] c_ALU_SLL   = 4'b1001;
    localparam logic [3:0] c_ALU_SRA   = 4'b1010;
    localparam logic [3:0] c_ALU_SLT   = 4'b1101;
    localparam logic [3:0] c_ALU_SLTU  = 4'b1111;

    typedef struct packed {
        logic [3:0]  alufn;
        logic [4:0]  shamt;
        logic        shamt_sel;
        logic        b_imm;
        logic        a_pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } dec_t;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_f7_zero;
    logic        w_f7_alt;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [3:0]  w_f3_alufn;
    logic        w_legal;
    logic [3:0]  w_alufn;
    logic        w_shamt_sel;
    logic        w_b_imm;
    logic        w_a_pc;
    logic [31:0] w_imm;
    dec_t        w_dec;
    dec_t        w_out;
    logic        w_accept;
    logic        w_free;

    logic        r_main_valid;
    dec_t        r_main;

    assign w_opc     = in_instr[6:0];
    assign w_f3      = in_instr[14:12];
    assign w_f7      = in_instr[31:25];
    assign w_f7_zero = (w_f7 == 7'b0000000);
    assign w_f7_alt  = (w_f7 == 7'b0100000);

    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'h000};

    // Base funct3 map shared by OP and OP-IMM; SUB/SRA are patched in below.
    always_comb begin
        w_f3_alufn = c_ALU_ADD;
        case (w_f3)
            3'b000:  w_f3_alufn = c_ALU_ADD;
            3'b001:  w_f3_alufn = c_ALU_SLL;
            3'b010:  w_f3_alufn = c_ALU_SLT;
            3'b011:  w_f3_alufn = c_ALU_SLTU;
            3'b100:  w_f3_alufn = c_ALU_XOR;
            3'b101:  w_f3_alufn = c_ALU_SRL;
            3'b110:  w_f3_alufn = c_ALU_OR;
            default: w_f3_alufn = c_ALU_AND;
        endcase
    end

    always_comb begin
        w_legal     = 1'b1;
        w_alufn     = RST_ALUFN;
        w_shamt_sel = 1'b0;
        w_b_imm     = 1'b0;
        w_a_pc      = 1'b0;
        w_imm       = 32'h0;
        case (w_opc)
            c_OPC_OP: begin
                w_legal = w_f7_zero || (w_f7_alt && (w_f3 == 3'b000 || w_f3 == 3'b101));
                w_alufn = w_f3_alufn;
                if (w_f7_alt && w_f3 == 3'b000) w_alufn = c_ALU_SUB;
                if (w_f7_alt && w_f3 == 3'b101) w_alufn = c_ALU_SRA;
            end
            c_OPC_OPIMM: begin
                w_b_imm     = 1'b1;
                w_imm       = w_imm_i;
                w_alufn     = w_f3_alufn;
                w_shamt_sel = (w_f3 == 3'b001) || (w_f3 == 3'b101);
                if (w_f3 == 3'b001) w_legal = w_f7_zero;
                if (w_f3 == 3'b101) w_legal = w_f7_zero || w_f7_alt;
                if (w_f3 == 3'b101 && w_f7_alt) w_alufn = c_ALU_SRA;
            end
            c_OPC_LUI: begin
                w_alufn = c_ALU_PASSB;
                w_b_imm = 1'b1;
                w_imm   = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_alufn = c_ALU_ADD;
                w_a_pc  = 1'b1;
                w_b_imm = 1'b1;
                w_imm   = w_imm_u;
            end
            c_OPC_LOAD, c_OPC_JALR: begin
                w_alufn = c_ALU_ADD;
                w_b_imm = 1'b1;
                w_imm   = w_imm_i;
            end
            c_OPC_STORE: begin
                w_alufn = c_ALU_ADD;
                w_b_imm = 1'b1;
                w_imm   = w_imm_s;
            end
            c_OPC_BRANCH: begin
                w_alufn = c_ALU_SUB;
                w_imm   = w_imm_b;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Register index and shamt fields pass through raw; illegal entries zero all selects.
    always_comb begin
        w_dec         = '0;
        w_dec.alufn   = RST_ALUFN;
        w_dec.shamt   = in_instr[24:20];
        w_dec.rs1     = in_instr[19:15];
        w_dec.rs2     = in_instr[24:20];
        w_dec.rd      = in_instr[11:7];
        w_dec.illegal = !w_legal;
        if (w_legal) begin
            w_dec.alufn     = w_alufn;
            w_dec.shamt_sel = w_shamt_sel;
            w_dec.b_imm     = w_b_imm;
            w_dec.a_pc      = w_a_pc;
            w_dec.imm       = w_imm;
        end
    end

    assign w_free = !r_main_valid || out_ready;

`ifdef PRV32_ALU_ISSUE_SKID_EN
    logic r_skid_valid;
    dec_t r_skid;

    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_free) begin
            // in_ready is low whenever skid holds an entry, so no accept collides with the move.
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) r_main <= w_dec;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end
`else
    assign in_ready = w_free;
    assign w_accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main       <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main_valid <= 1'b1;
            r_main       <= w_dec;
        end else if (out_ready) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

    // Idle outputs present the reset entry so alufn rests at RST_ALUFN.
    always_comb begin
        w_out       = '0;
        w_out.alufn = RST_ALUFN;
        if (r_main_valid) w_out = r_main;
    end

    assign out_valid     = r_main_valid;
    assign out_alufn     = w_out.alufn;
    assign out_shamt     = w_out.shamt;
    assign out_shamt_sel = w_out.shamt_sel;
    assign out_b_imm     = w_out.b_imm;
    assign out_a_pc      = w_out.a_pc;
    assign out_imm       = w_out.imm;
    assign out_rs1       = w_out.rs1;
    assign out_rs2       = w_out.rs2;
    assign out_rd        = w_out.rd;
    assign out_illegal   = w_out.illegal;

endmodule

`default_nettype wire
